// File: rtl/frame_loader_if.sv
// rtl/frame_loader_if.sv - command, pixel-stream and frame-buffer write signals of frame_loader
//
// Purpose: groups every non-clock, non-reset signal of frame_loader into one bundle.
// Ports (slave = loader side):
//   start_load, start_clear, fill_value      command pulses and the clear fill byte
//   pix_data, pix_valid, pix_ready           incoming pixel stream handshake
//   wren, wraddress, data                    frame-buffer write port
//   busy, done, frame_count                  status
interface frame_loader_if;
   logic        start_load;
   logic        start_clear;
   logic [7:0]  fill_value;
   logic [7:0]  pix_data;
   logic        pix_valid;
   logic        pix_ready;
   logic        wren;
   logic [17:0] wraddress;
   logic [31:0] data;
   logic        busy;
   logic        done;
   logic [7:0]  frame_count;

   modport slave (
      input  start_load, start_clear, fill_value, pix_data, pix_valid,
      output pix_ready, wren, wraddress, data, busy, done, frame_count
   );

   modport master (
      output start_load, start_clear, fill_value, pix_data, pix_valid,
      input  pix_ready, wren, wraddress, data, busy, done, frame_count
   );
endinterface

// File: rtl/frame_loader.sv
// rtl/frame_loader.sv - streams or fills one image of pixels into a frame buffer
//
// Purpose: a load accepts IMG_W*IMG_H bytes over a valid/ready handshake and writes
// each to BASE_ADDR+index; a clear writes a latched fill byte to the same area at one
// pixel per cycle. Writes are registered and appear the cycle after acceptance.
// Ports:
//   clk    single clock
//   reset  asynchronous, active-low reset
//   bus    frame_loader_if.slave (commands, pixel stream, write port, status)
module frame_loader #(
   parameter int          IMG_W     = 256,
   parameter int          IMG_H     = 256,
   parameter logic [17:0] BASE_ADDR = 18'h0
) (
   input  logic          clk,
   input  logic          reset,
   frame_loader_if.slave bus
);
   localparam int          TOTAL    = IMG_W * IMG_H;
   localparam logic [17:0] LAST_IDX = 18'(TOTAL - 1);

   typedef enum logic [1:0] {IDLE, LOAD, CLEAR, FINISH} state_t;

   state_t      state;
   state_t      state_next;
   logic [17:0] idx;
   logic [7:0]  fill_q;
   logic        was_load;
   logic [7:0]  frame_count_q;
   logic        wren_q;
   logic [17:0] wraddress_q;
   logic [31:0] data_q;
   logic        accept;
   logic        write_now;
   logic        last_pix;
   logic [7:0]  pix_byte;

   assign accept    = (state == LOAD) && bus.pix_valid;
   assign write_now = accept || (state == CLEAR);
   assign last_pix  = (idx == LAST_IDX);
   assign pix_byte  = (state == CLEAR) ? fill_q : bus.pix_data;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Start pulses are only looked at in IDLE; load has priority over clear.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (bus.start_load) begin
               state_next = LOAD;
            end else if (bus.start_clear) begin
               state_next = CLEAR;
            end
         end
         LOAD: begin
            if (accept && last_pix) begin
               state_next = FINISH;
            end
         end
         CLEAR: begin
            if (last_pix) begin
               state_next = FINISH;
            end
         end
         FINISH:  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         idx           <= '0;
         fill_q        <= '0;
         was_load      <= 1'b0;
         frame_count_q <= '0;
         wren_q        <= 1'b0;
         wraddress_q   <= '0;
         data_q        <= '0;
      end else begin
         wren_q <= write_now;
         if (write_now) begin
            wraddress_q <= BASE_ADDR + idx;
            data_q      <= {24'h0, pix_byte};
            idx         <= idx + 18'd1;
         end
         if (state == IDLE) begin
            idx <= '0;
            if (bus.start_load) begin
               was_load <= 1'b1;
            end else if (bus.start_clear) begin
               was_load <= 1'b0;
               fill_q   <= bus.fill_value;
            end
         end
         // Only completed loads count as frames; clears leave the counter alone.
         if (state == FINISH && was_load) begin
            frame_count_q <= frame_count_q + 8'd1;
         end
      end
   end

   assign bus.pix_ready   = (state == LOAD);
   assign bus.busy        = (state != IDLE);
   assign bus.done        = (state == FINISH);
   assign bus.wren        = wren_q;
   assign bus.wraddress   = wraddress_q;
   assign bus.data        = data_q;
   assign bus.frame_count = frame_count_q;
endmodule

// File: tb/tb_frame_loader.sv
// tb/tb_frame_loader.sv - self-checking bench for frame_loader
module tb_frame_loader;
   localparam int          W     = 4;
   localparam int          H     = 2;
   localparam int          TOTAL = W * H;
   localparam logic [17:0] BASE  = 18'h100;

   logic clk = 1'b0;
   logic reset = 1'b0;
   int   n_cmp = 0;
   int   n_err = 0;
   logic [7:0] fc_exp = 8'd0;

   frame_loader_if bus ();

   frame_loader #(.IMG_W(W), .IMG_H(H), .BASE_ADDR(BASE)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // After the last write of a job: one idle cycle with no write, no done.
   task automatic check_idle_after(input string tag);
      check({tag, "_done"}, bus.done, 0);
      check({tag, "_busy"}, bus.busy, 0);
      check({tag, "_wren"}, bus.wren, 0);
      check({tag, "_ready"}, bus.pix_ready, 0);
      check({tag, "_fc"}, bus.frame_count, fc_exp);
   endtask

   // mode 0: continuous valid, 1: valid toggles 1,0,..., 2: random valid
   task automatic do_load(input int mode, input bit with_clear, input bit seq_bytes,
                          input bit hold_valid);
      logic [7:0] bytes [TOTAL];
      int n;
      int cyc;
      bit v;
      for (int i = 0; i < TOTAL; i++) bytes[i] = seq_bytes ? 8'(8'h10 + i) : 8'($urandom);
      bus.start_load  = 1'b1;
      bus.start_clear = with_clear;
      bus.fill_value  = 8'($urandom);
      tick();
      bus.start_load  = 1'b0;
      bus.start_clear = 1'b0;
      check("load_enter_ready", bus.pix_ready, 1);
      check("load_enter_wren", bus.wren, 0);
      n = 0;
      cyc = 0;
      while (n < TOTAL && cyc < 400) begin
         case (mode)
            0:       v = 1'b1;
            1:       v = (cyc % 2 == 0);
            default: v = 1'($urandom_range(0, 1));
         endcase
         bus.pix_valid   = v;
         bus.pix_data    = v ? bytes[n] : 8'($urandom);
         bus.start_clear = with_clear && (cyc == 3);
         tick();
         cyc++;
         bus.start_clear = 1'b0;
         if (v) begin
            check("load_wren", bus.wren, 1);
            check("load_addr", bus.wraddress, 32'(18'(BASE + 18'(n))));
            check("load_data", bus.data, {24'h0, bytes[n]});
            n++;
            check("load_ready", bus.pix_ready, (n < TOTAL));
            check("load_done", bus.done, (n == TOTAL));
         end else begin
            check("load_gap_wren", bus.wren, 0);
            check("load_gap_done", bus.done, 0);
         end
      end
      check("load_count", n, TOTAL);
      fc_exp = fc_exp + 8'd1;
      bus.pix_valid = hold_valid;
      bus.pix_data  = 8'($urandom);
      tick();
      check_idle_after("load_end");
      if (hold_valid) begin
         tick();
         check_idle_after("load_hold");
      end
      bus.pix_valid = 1'b0;
   endtask

   task automatic do_clear(input logic [7:0] fill, input bit with_load_pulse);
      bus.start_clear = 1'b1;
      bus.fill_value  = fill;
      tick();
      bus.start_clear = 1'b0;
      bus.fill_value  = ~fill;
      check("clr_enter_busy", bus.busy, 1);
      check("clr_enter_ready", bus.pix_ready, 0);
      check("clr_enter_wren", bus.wren, 0);
      for (int i = 0; i < TOTAL; i++) begin
         bus.start_load = with_load_pulse && (i == 2);
         tick();
         bus.start_load = 1'b0;
         check("clr_wren", bus.wren, 1);
         check("clr_addr", bus.wraddress, 32'(18'(BASE + 18'(i))));
         check("clr_data", bus.data, {24'h0, fill});
         check("clr_ready", bus.pix_ready, 0);
         check("clr_done", bus.done, (i == TOTAL - 1));
      end
      tick();
      check_idle_after("clr_end");
   endtask

   initial begin
      bus.start_load  = 1'b0;
      bus.start_clear = 1'b0;
      bus.fill_value  = 8'h00;
      bus.pix_data    = 8'h00;
      bus.pix_valid   = 1'b0;

      // Reset state
      repeat (3) tick();
      check("rst_wren", bus.wren, 0);
      check("rst_addr", bus.wraddress, 0);
      check("rst_data", bus.data, 0);
      check("rst_done", bus.done, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_ready", bus.pix_ready, 0);
      check("rst_fc", bus.frame_count, 0);
      reset = 1'b1;
      tick();
      check("idle_busy", bus.busy, 0);

      // Sequential bytes, continuous valid
      do_load(0, 1'b0, 1'b1, 1'b0);
      // Toggled valid
      do_load(1, 1'b0, 1'b1, 1'b0);
      // Clear with 0xAA, a load pulse inside it is ignored
      do_clear(8'hAA, 1'b1);
      do_clear(8'($urandom), 1'b0);
      // Load and clear together, clear pulse during load
      do_load(2, 1'b1, 1'b0, 1'b1);

      // Reset after 3 accepted pixels
      bus.start_load = 1'b1;
      tick();
      bus.start_load = 1'b0;
      bus.pix_valid  = 1'b1;
      for (int i = 0; i < 3; i++) begin
         bus.pix_data = 8'($urandom);
         tick();
         check("pre_rst_wren", bus.wren, 1);
      end
      reset = 1'b0;
      #1;
      fc_exp = 8'd0;
      check("abort_wren", bus.wren, 0);
      check("abort_busy", bus.busy, 0);
      check("abort_done", bus.done, 0);
      check("abort_fc", bus.frame_count, 0);
      bus.pix_valid  = 1'b0;
      bus.start_load = 1'b1;
      tick();
      bus.start_load = 1'b0;
      reset = 1'b1;
      tick();
      check("lost_start_busy", bus.busy, 0);
      check("lost_start_done", bus.done, 0);
      check("lost_start_addr", bus.wraddress, 0);
      do_load(0, 1'b0, 1'b1, 1'b0);

      // 256 loads in total since reset: counter wraps to 0
      for (int k = 1; k < 256; k++) do_load(int'($urandom_range(0, 2)), 1'b0, 1'b0, k == 255);
      check("fc_wrap", bus.frame_count, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/frame_loader.md
FRAME_LOADER -- requirements
Module: frame_loader

Interface
REQ-001 Parameter IMG_W, default 256, pixels per image row.
REQ-002 Parameter IMG_H, default 256, image rows; IMG_W*IMG_H SHALL be <= 262144.
REQ-003 Parameter BASE_ADDR, default 0, 18-bit frame-buffer address of pixel (0,0).
REQ-004 clk  in  1  single clock for all logic.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 start_load  in  1  one-cycle pulse that begins a pixel-stream load.
REQ-007 start_clear  in  1  one-cycle pulse that begins a fill of the image area.
REQ-008 fill_value  in  8  pixel value written during a clear, sampled at start_clear.
REQ-009 pix_data  in  8  incoming pixel byte.
REQ-010 pix_valid  in  1  pix_data is valid.
REQ-011 pix_ready  out  1  loader accepts pix_data this cycle.
REQ-012 wren  out  1  frame-buffer write enable.
REQ-013 wraddress  out  18  frame-buffer write address.
REQ-014 data  out  32  frame-buffer write data, pixel in bits [7:0], bits [31:8] zero.
REQ-015 busy  out  1  load or clear in progress.
REQ-016 done  out  1  one-cycle pulse on completion of a load or clear.
REQ-017 frame_count  out  8  completed loads, wraps 255->0.

Function
REQ-018 FSM states SHALL be IDLE, LOAD, CLEAR, FINISH.
REQ-019 IDLE->LOAD on start_load; IDLE->CLEAR on start_clear; both asserted together -> LOAD wins and start_clear is dropped.
REQ-020 start_load/start_clear outside IDLE SHALL be ignored, with no effect on counters or outputs.
REQ-021 Entering LOAD or CLEAR SHALL zero the pixel index idx (18 bit).
REQ-022 pix_ready SHALL be 1 only in LOAD, combinationally from state, independent of pix_valid.
REQ-023 Handshake: a pixel is accepted on a rising edge where pix_valid=1 and pix_ready=1; idx increments by 1 per accepted pixel.
REQ-024 Outputs are registered: on the edge after acceptance, wren=1, wraddress=BASE_ADDR+idx(at acceptance), data={24'h0,pix_data}.
REQ-025 wren SHALL be 0 in every cycle that follows no accepted pixel or clear write.
REQ-026 CLEAR writes one pixel per cycle, no handshake: wren=1, data={24'h0,fill_value latched}, wraddress=BASE_ADDR+idx, idx incremented each cycle.
REQ-027 When the pixel with idx=IMG_W*IMG_H-1 is accepted or written, the FSM SHALL go to FINISH on the same edge; pix_ready is 0 from that edge onward.
REQ-028 FINISH lasts exactly one cycle: done=1, busy=1; next state IDLE.
REQ-029 frame_count SHALL increment on the FINISH cycle only when it ends a LOAD.
REQ-030 busy=1 in LOAD, CLEAR, FINISH; 0 in IDLE.
REQ-031 Bytes presented with pix_valid while pix_ready=0 SHALL be neither written nor counted.
REQ-032 wraddress arithmetic is 18-bit modulo 2^18.
REQ-033 Latency: first write appears 1 cycle after the first accepted pixel; done appears 1 cycle after the last write is issued.

Reset
REQ-034 reset=0 SHALL asynchronously force state IDLE, idx=0, wren=0, wraddress=0, data=0, done=0, frame_count=0, latched fill=0.
REQ-035 Reset during LOAD or CLEAR SHALL abort with no further write and no done pulse; any write in flight is cancelled.
REQ-036 Deassertion of reset takes effect on the next rising edge; start pulses sampled while reset=0 are lost.

Verification
REQ-037 IMG_W=4, IMG_H=2, BASE_ADDR=18'h100; start_load, stream 8 bytes 0x10..0x17 with continuous valid -> writes to 0x100..0x107 with data 0x10..0x17, done 1 cycle after the last write, frame_count=1.
REQ-038 Same config; pix_valid toggled 1,0,1,0 -> exactly 8 writes, no gaps mis-addressed, wren=0 in cycles following valid=0.
REQ-039 start_clear with fill_value=0xAA -> 8 consecutive cycles of wren=1 at 0x100..0x107 with data 32'h000000AA, done pulse, frame_count unchanged.
REQ-040 start_load and start_clear together -> LOAD only; start_clear pulsed during LOAD -> ignored.
REQ-041 reset=0 after 3 accepted pixels -> wren=0 immediately, no done; new start_load restarts at 0x100.
REQ-042 256 back-to-back loads -> frame_count wraps to 0; pix_valid held after done -> pix_ready=0, no writes.
